// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
// Shared definitions for the execute stage: bus widths, ALU operation and
// result-select encodings, reset/write-enable constants, the two pipeline
// register layouts and the forwarding write-enable helper.
package ex_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;

    // Reset for this block is active-low
    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    typedef enum logic [ALUOP_W-1:0] {
        EXE_NOP_OP = 8'b0000_0000,
        EXE_SRL_OP = 8'b0000_0010,
        EXE_SRA_OP = 8'b0000_0011,
        EXE_AND_OP = 8'b0010_0100,
        EXE_OR_OP  = 8'b0010_0101,
        EXE_XOR_OP = 8'b0010_0110,
        EXE_NOR_OP = 8'b0010_0111,
        EXE_SLL_OP = 8'b0111_1100
    } aluop_e;

    typedef enum logic [ALUSEL_W-1:0] {
        EXE_RES_NOP   = 3'b000,
        EXE_RES_LOGIC = 3'b001,
        EXE_RES_SHIFT = 3'b010
    } alusel_e;

    // ID/EX register contents; all-zero is a NOP bubble
    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic [ALUSEL_W-1:0]   alusel;
        logic [REG_W-1:0]      reg1;
        logic [REG_W-1:0]      reg2;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } id_ex_t;

    // EX/MEM register contents
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } ex_mem_t;

    // A write to register 0 is optionally killed so it can never be forwarded
    function automatic logic fwd_we(input logic wreg,
                                    input logic [REG_ADDR_W-1:0] wd,
                                    input logic suppress_r0);
        return wreg & ~(suppress_r0 & (wd == '0));
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if
// Decoder-side bus of the execute stage: decoded instruction fields, stall and
// flush control in; EX and MEM forwarding buses plus retired count out.
//   master : decoder / stall controller side (drives id_*, stall_i, flush_i)
//   slave  : ex_stage side (drives ex_*, mem_*, inst_cnt_o)
interface ex_stage_if
    import ex_stage_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [ALUOP_W-1:0]    id_aluop_i;
    logic [ALUSEL_W-1:0]   id_alusel_i;
    logic [REG_W-1:0]      id_reg1_i;
    logic [REG_W-1:0]      id_reg2_i;
    logic [REG_ADDR_W-1:0] id_wd_i;
    logic                  id_wreg_i;
    logic [2:0]            stall_i;
    logic                  flush_i;

    logic                  ex_we_o;
    logic [REG_ADDR_W-1:0] ex_wreg_addr_o;
    logic [REG_W-1:0]      ex_wreg_data_o;
    logic                  mem_we_o;
    logic [REG_ADDR_W-1:0] mem_wreg_addr_o;
    logic [REG_W-1:0]      mem_wreg_data_o;
    logic [CNT_W-1:0]      inst_cnt_o;

    modport master (
        output id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
        output stall_i, flush_i,
        input  ex_we_o, ex_wreg_addr_o, ex_wreg_data_o,
        input  mem_we_o, mem_wreg_addr_o, mem_wreg_data_o, inst_cnt_o
    );

    modport slave (
        input  id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i,
        input  stall_i, flush_i,
        output ex_we_o, ex_wreg_addr_o, ex_wreg_data_o,
        output mem_we_o, mem_wreg_addr_o, mem_wreg_data_o, inst_cnt_o
    );

endinterface

// File: rtl/ex_stage_alu.sv
// ex_alu
// Purely combinational logic/shift ALU.
//   aluop_i  : operation code
//   alusel_i : result group select (logic / shift / nop)
//   reg1_i   : operand 1 (shift amount in bits [4:0] for shifts)
//   reg2_i   : operand 2 (value being shifted for shifts)
//   result_o : selected result, zero for NOP or any unknown code
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [REG_W-1:0]    reg1_i,
    input  logic [REG_W-1:0]    reg2_i,
    output logic [REG_W-1:0]    result_o
);

    logic [4:0]       sh;
    logic [REG_W-1:0] logic_res;
    logic [REG_W-1:0] shift_res;

    assign sh = reg1_i[4:0];

    always_comb begin
        logic_res = ZERO_WORD;
        case (aluop_i)
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = ZERO_WORD;
        endcase
    end

    always_comb begin
        shift_res = ZERO_WORD;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << sh;
            EXE_SRL_OP: shift_res = reg2_i >> sh;
            EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> sh);
            default:    shift_res = ZERO_WORD;
        endcase
    end

    always_comb begin
        result_o = ZERO_WORD;
        case (alusel_i)
            EXE_RES_LOGIC: result_o = logic_res;
            EXE_RES_SHIFT: result_o = shift_res;
            default:       result_o = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage: ID/EX register -> logic/shift ALU -> EX/MEM register.
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : ex_stage_if slave; decoded fields, stall {mem,ex,id}, flush in;
//           EX forwarding (combinational from ID/EX), EX/MEM register
//           (also MEM forwarding) and retired-instruction count out.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    id_ex_t           id_ex_d, id_ex_q;
    ex_mem_t          ex_mem_d, ex_mem_q;
    logic [CNT_W-1:0] inst_cnt_d, inst_cnt_q;
    logic [REG_W-1:0] alu_result;
    logic             ex_we;

    assign ex_we = fwd_we(id_ex_q.wreg, id_ex_q.wd, SUPPRESS_R0);

    ex_alu u_alu (
        .aluop_i  (id_ex_q.aluop),
        .alusel_i (id_ex_q.alusel),
        .reg1_i   (id_ex_q.reg1),
        .reg2_i   (id_ex_q.reg2),
        .result_o (alu_result)
    );

    // A bubble is injected only when this stage stalls but the next one does
    // not; when both stall the register simply holds.
    always_comb begin
        id_ex_d = id_ex_q;
        if (bus.flush_i) begin
            id_ex_d = '0;
        end else if (bus.stall_i[0] && !bus.stall_i[1]) begin
            id_ex_d = '0;
        end else if (!bus.stall_i[0]) begin
            id_ex_d = '{aluop:  bus.id_aluop_i,
                        alusel: bus.id_alusel_i,
                        reg1:   bus.id_reg1_i,
                        reg2:   bus.id_reg2_i,
                        wd:     bus.id_wd_i,
                        wreg:   bus.id_wreg_i};
        end
    end

    // The retired count only moves on a real load of a non-bubble instruction
    always_comb begin
        ex_mem_d   = ex_mem_q;
        inst_cnt_d = inst_cnt_q;
        if (bus.flush_i) begin
            ex_mem_d = '0;
        end else if (bus.stall_i[1] && !bus.stall_i[2]) begin
            ex_mem_d = '{we: WRITE_DISABLE, addr: '0, data: ZERO_WORD};
        end else if (!bus.stall_i[1]) begin
            ex_mem_d = '{we: ex_we, addr: id_ex_q.wd, data: alu_result};
            if (ex_we || (id_ex_q.aluop != EXE_NOP_OP)) begin
                inst_cnt_d = inst_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            id_ex_q    <= '0;
            ex_mem_q   <= '0;
            inst_cnt_q <= '0;
        end else begin
            id_ex_q    <= id_ex_d;
            ex_mem_q   <= ex_mem_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign bus.ex_we_o         = ex_we;
    assign bus.ex_wreg_addr_o  = id_ex_q.wd;
    assign bus.ex_wreg_data_o  = alu_result;
    assign bus.mem_we_o        = ex_mem_q.we;
    assign bus.mem_wreg_addr_o = ex_mem_q.addr;
    assign bus.mem_wreg_data_o = ex_mem_q.data;
    assign bus.inst_cnt_o      = inst_cnt_q;

endmodule
